// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues block-aligned fetches (one outstanding) and unpacks responses into packets.
// Latency: request addr is combinational from pc; response packets/num_accept combinational with mem_resp_valid.
// Backpressure: request is held (addr may change on redirect) until mem_req_ready; no issue unless buffer has N free slots.

package fetch_pkg;
    typedef struct packed {
        logic        valid;
        logic        pred_taken;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
    } inst_packet_t;
endpackage

module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          N        = 4,
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    input  logic [$clog2(DEPTH+1)-1:0] open_entries,
    output logic                       mem_req_valid,
    output logic [31:0]                mem_req_addr,
    input  logic                       mem_req_ready,
    input  logic                       mem_resp_valid,
    input  logic [N*32-1:0]            mem_resp_data,
    output inst_packet_t [N-1:0]       out_insts,
    output logic [$clog2(N+1)-1:0]     num_accept,
    output logic [31:0]                debug_pc
);

    localparam int          NA_W      = $clog2(N + 1);
    localparam logic [31:0] BLK_BYTES = 32'(N * 4);
    localparam logic [31:0] BLK_MASK  = ~(BLK_BYTES - 32'd1);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;

    logic [31:0]     blk_base;
    logic [31:0]     off;
    logic [N*32-1:0] resp_shift;
    logic            req_fire;
    logic            resp_take;

    // Request side and response unpacking; the first useful word is shifted down to slot 0.
    always_comb begin
        blk_base      = pc_q & BLK_MASK;
        off           = (pc_q >> 2) & (32'(N) - 32'd1);
        resp_shift    = mem_resp_data >> (off * 32'd32);
        mem_req_valid = !reset && (state_q == S_REQ) && (32'(open_entries) >= 32'(N));
        mem_req_addr  = blk_base;
        req_fire      = mem_req_valid && mem_req_ready;
        // A redirect in the same cycle as the response kills it.
        resp_take     = !reset && (state_q == S_WAIT) && mem_resp_valid && !redirect_valid;
        num_accept    = resp_take ? NA_W'(32'(N) - off) : '0;
        out_insts     = '0;
        if (resp_take) begin
            for (int k = 0; k < N; k++) begin
                if (32'(k) < (32'(N) - off)) begin
                    out_insts[k].valid = 1'b1;
                    out_insts[k].inst  = resp_shift[k*32 +: 32];
                    out_insts[k].pc    = blk_base + ((off + 32'(k)) << 2);
                    out_insts[k].npc   = blk_base + ((off + 32'(k)) << 2) + 32'd4;
                end
            end
        end
        debug_pc = pc_q;
    end

    // Next-state and next-pc; redirect overrides every other event.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    // An accepted old-address request must still be drained.
                    state_d = req_fire ? S_DRAIN : S_REQ;
                end else if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = mem_resp_valid ? S_REQ : S_DRAIN;
                end else if (mem_resp_valid) begin
                    pc_d    = blk_base + BLK_BYTES;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (mem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // State and pc registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule
